wishbone_sram_slave: RTL and testbench

WISHBONE_SRAM_SLAVE -- requirements
Module: wishbone_sram_slave

---
 rtl/wishbone_sram_slave.sv | 174 +++++++++++++++++
 tb/tb_wishbone_sram_slave.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_sram_slave.sv
// Wishbone-to-asynchronous-SRAM bridge: captures one bus request, sequences
// the SRAM strobes for a timed read or write, then returns a single-cycle ack.
module wishbone_sram_slave #(
  parameter int DEV_BIT    = 4,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_we_i,
  input  logic [15:0] wishbone_select_i,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_ack_o,
  output logic [19:0] sram_addr_o,
  input  logic [31:0] sram_data_i,
  output logic [31:0] sram_data_o,
  output logic        sram_data_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_WAIT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ACK
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [19:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  sel_reg, sel_next;
  logic [31:0] dout_reg, dout_next;

  logic        ack_reg, ack_next;
  logic        ce_n_reg, ce_n_next;
  logic        oe_n_reg, oe_n_next;
  logic        we_n_reg, we_n_next;
  logic        doe_reg, doe_next;
  logic [3:0]  be_n_reg, be_n_next;

  logic        rd_phase, wr_phase;

  // Bus bits outside the captured fields are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{wishbone_addr_i[31:22], wishbone_addr_i[1:0], wishbone_select_i};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    sel_next   = sel_reg;
    dout_next  = dout_reg;

    case (state_reg)
      IDLE: begin
        if (wishbone_select_i[DEV_BIT]) begin
          addr_next  = wishbone_addr_i[21:2];
          wdata_next = wishbone_data_i;
          sel_next   = wishbone_select_i[3:0];
          if (wishbone_select_i[3:0] == 4'h0) begin
            // No byte lanes enabled: complete at once without touching the SRAM.
            state_next = ACK;
            dout_next  = 32'h0;
          end else if (wishbone_we_i) begin
            state_next = WR_SETUP;
          end else begin
            state_next = RD_SETUP;
          end
        end
      end
      RD_SETUP: begin
        cnt_next   = RD_LOAD;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_reg == 4'd0) begin
          dout_next  = sram_data_i;
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WR_SETUP: begin
        cnt_next   = WR_LOAD;
        state_next = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_reg == 4'd0) begin
          state_next = WR_HOLD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WR_HOLD: begin
        dout_next  = 32'h0;
        state_next = ACK;
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so the pins are glitch-free
  // and fall inactive on the very edge that sees reset.
  always_comb begin
    rd_phase  = (state_next == RD_SETUP) || (state_next == RD_WAIT);
    wr_phase  = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                (state_next == WR_HOLD);
    ack_next  = (state_next == ACK);
    ce_n_next = !(rd_phase || wr_phase);
    oe_n_next = !rd_phase;
    we_n_next = (state_next != WR_PULSE);
    doe_next  = wr_phase;
    be_n_next = (rd_phase || wr_phase) ? ~sel_next : 4'hF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 20'h0;
      wdata_reg <= 32'h0;
      sel_reg   <= 4'h0;
      dout_reg  <= 32'h0;
      ack_reg   <= 1'b0;
      ce_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
      doe_reg   <= 1'b0;
      be_n_reg  <= 4'hF;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      sel_reg   <= sel_next;
      dout_reg  <= dout_next;
      ack_reg   <= ack_next;
      ce_n_reg  <= ce_n_next;
      oe_n_reg  <= oe_n_next;
      we_n_reg  <= we_n_next;
      doe_reg   <= doe_next;
      be_n_reg  <= be_n_next;
    end
  end

  assign wishbone_data_o = dout_reg;
  assign wishbone_ack_o  = ack_reg;
  assign sram_addr_o     = addr_reg;
  assign sram_data_o     = wdata_reg;
  assign sram_data_oe    = doe_reg;
  assign sram_ce_n       = ce_n_reg;
  assign sram_oe_n       = oe_n_reg;
  assign sram_we_n       = we_n_reg;
  assign sram_be_n       = be_n_reg;

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// Bench for wishbone_sram_slave: default-timing and fast-read/slow-write
// instances share one bus and are checked against the same vector table.
module tb_wishbone_sram_slave;

  logic        clk;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_we;
  logic [15:0] bus_sel;
  logic [31:0] sram_rdata;

  logic [31:0] dout_w [2];
  logic        ack_w  [2];
  logic [19:0] addr_w [2];
  logic [31:0] sdo_w  [2];
  logic        doe_w  [2];
  logic        ce_w   [2];
  logic        oe_w   [2];
  logic        we_w   [2];
  logic [3:0]  be_w   [2];

  int total = 0;
  int bad = 0;
  int overlap = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wishbone_sram_slave #(.DEV_BIT(4), .READ_WAIT(2), .WRITE_WAIT(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .wishbone_addr_i(bus_addr), .wishbone_data_i(bus_data),
    .wishbone_we_i(bus_we), .wishbone_select_i(bus_sel),
    .wishbone_data_o(dout_w[0]), .wishbone_ack_o(ack_w[0]),
    .sram_addr_o(addr_w[0]), .sram_data_i(sram_rdata),
    .sram_data_o(sdo_w[0]), .sram_data_oe(doe_w[0]),
    .sram_ce_n(ce_w[0]), .sram_oe_n(oe_w[0]), .sram_we_n(we_w[0]),
    .sram_be_n(be_w[0])
  );

  wishbone_sram_slave #(.DEV_BIT(4), .READ_WAIT(1), .WRITE_WAIT(5)) u_dut1 (
    .clk(clk), .rst(rst),
    .wishbone_addr_i(bus_addr), .wishbone_data_i(bus_data),
    .wishbone_we_i(bus_we), .wishbone_select_i(bus_sel),
    .wishbone_data_o(dout_w[1]), .wishbone_ack_o(ack_w[1]),
    .sram_addr_o(addr_w[1]), .sram_data_i(sram_rdata),
    .sram_data_o(sdo_w[1]), .sram_data_oe(doe_w[1]),
    .sram_ce_n(ce_w[1]), .sram_oe_n(oe_w[1]), .sram_we_n(we_w[1]),
    .sram_be_n(be_w[1])
  );

  // Data bus driven while the SRAM drives it would be a bus fight.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (doe_w[d] && !oe_w[d]) overlap++;
  end

  typedef struct {
    logic [15:0] sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [19:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_dout;
    int lat0, lat1, oe0, oe1, we0, we1, doe0, doe1;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string name);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_dut%0d", name, d),
          {3'b0, ack_w[d], dout_w[d], addr_w[d], sdo_w[d], doe_w[d], ce_w[d], oe_w[d], we_w[d], be_w[d]},
          {3'b0, 1'b0, 32'h0, 20'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF});
  endtask

  // Called at a negedge; capture happens at the following posedge.
  task automatic run_vec(input int idx, input vec_t v);
    int ackc[2], ackn[2], oec[2], wec[2], doec[2], cec[2];
    logic seen[2];
    logic [3:0]  be_seen[2];
    logic [19:0] addr_seen[2];
    logic [31:0] wd_seen[2];
    int exp_lat, exp_oe, exp_we, exp_doe;
    for (int d = 0; d < 2; d++) begin
      ackc[d] = 0; ackn[d] = 0; oec[d] = 0; wec[d] = 0; doec[d] = 0; cec[d] = 0;
      seen[d] = 1'b0; be_seen[d] = 4'hF; addr_seen[d] = 20'h0; wd_seen[d] = 32'h0;
    end
    bus_sel = v.sel; bus_we = v.we; bus_addr = v.addr; bus_data = v.wdata;
    sram_rdata = v.rdata;
    @(posedge clk);
    @(negedge clk);
    if (v.sel[4]) begin
      // Scramble the bus after capture; the slave must ignore it.
      bus_sel = 16'h0; bus_we = ~v.we; bus_addr = ~v.addr; bus_data = ~v.wdata;
    end
    for (int c = 1; c <= 20; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (ack_w[d]) begin
          ackn[d]++;
          if (ackc[d] == 0) ackc[d] = c;
        end
        if (!oe_w[d]) oec[d]++;
        if (!we_w[d]) begin wec[d]++; wd_seen[d] = sdo_w[d]; end
        if (doe_w[d]) doec[d]++;
        if (!ce_w[d]) begin
          cec[d]++;
          if (!seen[d]) begin seen[d] = 1'b1; be_seen[d] = be_w[d]; addr_seen[d] = addr_w[d]; end
        end
      end
      @(negedge clk);
    end
    bus_sel = 16'h0;
    for (int d = 0; d < 2; d++) begin
      exp_lat = (d == 0) ? v.lat0 : v.lat1;
      exp_oe  = (d == 0) ? v.oe0  : v.oe1;
      exp_we  = (d == 0) ? v.we0  : v.we1;
      exp_doe = (d == 0) ? v.doe0 : v.doe1;
      chk($sformatf("v%0d_d%0d_ack_cycle", idx, d), 96'(ackc[d]), 96'(exp_lat));
      chk($sformatf("v%0d_d%0d_ack_count", idx, d), 96'(ackn[d]), 96'((exp_lat > 0) ? 1 : 0));
      chk($sformatf("v%0d_d%0d_oe_cycles", idx, d), 96'(oec[d]), 96'(exp_oe));
      chk($sformatf("v%0d_d%0d_we_cycles", idx, d), 96'(wec[d]), 96'(exp_we));
      chk($sformatf("v%0d_d%0d_doe_cycles", idx, d), 96'(doec[d]), 96'(exp_doe));
      chk($sformatf("v%0d_d%0d_ce_cycles", idx, d), 96'(cec[d]), 96'(exp_oe + exp_doe));
      chk($sformatf("v%0d_d%0d_rdata", idx, d), 96'(dout_w[d]), 96'(v.exp_dout));
      if (exp_oe + exp_doe > 0) begin
        chk($sformatf("v%0d_d%0d_be_n", idx, d), 96'(be_seen[d]), 96'(v.exp_be));
        chk($sformatf("v%0d_d%0d_sram_addr", idx, d), 96'(addr_seen[d]), 96'(v.exp_addr));
      end
      if (exp_we > 0)
        chk($sformatf("v%0d_d%0d_sram_wdata", idx, d), 96'(wd_seen[d]), 96'(v.wdata));
    end
    $display("vec %0d sel=%h we=%0d addr=%h ack@%0d/%0d dout=%h/%h",
             idx, v.sel, v.we, v.addr, ackc[0], ackc[1], dout_w[0], dout_w[1]);
  endtask

  initial begin
    int acks[2], a1[2], a2[2];
    vecs[0] = '{16'h001F, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 20'h00004, 4'h0, 32'hDEAD_BEEF, 4, 3, 3, 2, 0, 0, 0, 0};
    vecs[1] = '{16'h0012, 1'b1, 32'h0000_0008, 32'h1122_3344, 32'h0, 20'h00002, 4'hD, 32'h0, 5, 8, 0, 0, 2, 5, 4, 7};
    vecs[2] = '{16'h002F, 1'b0, 32'h0000_0040, 32'h0, 32'h5555_5555, 20'h00010, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{16'h0010, 1'b0, 32'h0000_0080, 32'h0, 32'h7777_7777, 20'h00020, 4'hF, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{16'h001F, 1'b0, 32'h003F_FFFC, 32'h0, 32'hA5A5_5A5A, 20'hFFFFF, 4'h0, 32'hA5A5_5A5A, 4, 3, 3, 2, 0, 0, 0, 0};
    vecs[5] = '{16'h0010, 1'b1, 32'h0000_0100, 32'h9999_9999, 32'h0, 20'h00040, 4'hF, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{16'h0018, 1'b0, 32'h1234_5678, 32'h0, 32'hCAFE_F00D, 20'hD159E, 4'h7, 32'hCAFE_F00D, 4, 3, 3, 2, 0, 0, 0, 0};
    vecs[7] = '{16'h001F, 1'b1, 32'h0000_0004, 32'hFFFF_0000, 32'h0, 20'h00001, 4'h0, 32'h0, 5, 8, 0, 0, 2, 5, 4, 7};
    vecs[8] = '{16'h8014, 1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 20'h00040, 4'hB, 32'h0BAD_F00D, 4, 3, 3, 2, 0, 0, 0, 0};
    vecs[9] = '{16'hFFEF, 1'b1, 32'h0000_0200, 32'h1234_0000, 32'h0, 20'h00080, 4'h0, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; bus_sel = 16'h0; bus_we = 1'b0; bus_addr = 32'h0; bus_data = 32'h0; sram_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset_state");
    rst = 1'b0;
    // First vector is driven immediately so it is captured on the first edge out of reset.
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Back-to-back reads with the request held continuously.
    for (int d = 0; d < 2; d++) begin acks[d] = 0; a1[d] = 0; a2[d] = 0; end
    bus_sel = 16'h001F; bus_we = 1'b0; bus_addr = 32'h0000_0030; sram_rdata = 32'h1357_9BDF;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      for (int d = 0; d < 2; d++)
        if (ack_w[d]) begin
          acks[d]++;
          if (acks[d] == 1) a1[d] = c;
          if (acks[d] == 2) a2[d] = c;
        end
      if (c < 12) @(negedge clk);
    end
    bus_sel = 16'h0;
    chk("b2b_d0_first_ack", 96'(a1[0]), 96'(4));
    chk("b2b_d0_second_ack", 96'(a2[0]), 96'(9));
    chk("b2b_d0_ack_count", 96'(acks[0]), 96'(2));
    chk("b2b_d1_first_ack", 96'(a1[1]), 96'(3));
    chk("b2b_d1_second_ack", 96'(a2[1]), 96'(7));
    chk("b2b_d1_ack_count", 96'(acks[1]), 96'(3));
    chk("b2b_d0_rdata", 96'(dout_w[0]), 96'(32'h1357_9BDF));
    $display("b2b acks d0=%0d@%0d,%0d d1=%0d@%0d,%0d", acks[0], a1[0], a2[0], acks[1], a1[1], a2[1]);
    repeat (20) @(negedge clk);

    // Reset in the middle of a write pulse.
    bus_sel = 16'h001F; bus_we = 1'b1; bus_addr = 32'h0000_0020; bus_data = 32'h0F0F_F0F0;
    @(posedge clk);
    @(negedge clk);
    bus_sel = 16'h0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("midwr_pulse_d%0d", d), 96'({we_w[d], ce_w[d], doe_w[d]}), 96'(3'b001));
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("midwr_abort_d%0d", d),
          96'({we_w[d], ce_w[d], oe_w[d], doe_w[d], be_w[d], ack_w[d]}), 96'({4'b1110, 4'hF, 1'b0}));
    rst = 1'b0;
    for (int d = 0; d < 2; d++) acks[d] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < 2; d++) if (ack_w[d]) acks[d]++;
      @(negedge clk);
    end
    chk("midwr_no_ack_d0", 96'(acks[0]), 96'(0));
    chk("midwr_no_ack_d1", 96'(acks[1]), 96'(0));
    $display("reset mid-write: acks after abort d0=%0d d1=%0d", acks[0], acks[1]);
    run_vec(10, vecs[0]);

    chk("no_oe_doe_overlap", 96'(overlap), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
